// File: rtl/heap_alloc_if.sv
// Request/response bundle between an allocator client and heap_alloc.
// The client drives the i_* strobes; the allocator drives the o_* results.
interface heap_alloc_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
);
    logic               i_alloc;
    logic               i_free;
    logic               i_rd;
    logic [ADDR_SZ-1:0] i_addr;
    logic [DATA_SZ-1:0] i_data;
    logic               o_busy;
    logic               o_done;
    logic [ADDR_SZ-1:0] o_addr;
    logic [DATA_SZ-1:0] o_rdata;
    logic [ADDR_SZ-1:0] o_count;
    logic               o_error;

    modport master (
        output i_alloc, i_free, i_rd, i_addr, i_data,
        input  o_busy, o_done, o_addr, o_rdata, o_count, o_error
    );

    modport slave (
        input  i_alloc, i_free, i_rd, i_addr, i_data,
        output o_busy, o_done, o_addr, o_rdata, o_count, o_error
    );
endinterface

// File: rtl/heap_alloc.sv
// Cell allocator: bump pointer plus a LIFO free list whose links live
// inside the released cells. Address 0 is NIL and is never handed out.
module heap_alloc #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    heap_alloc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, POP, DONE} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_BUMP, OP_POPREQ, OP_POP,
        OP_FREE, OP_RECYC, OP_RD, OP_ERR
    } op_t;

    state_t             r_state;
    state_t             w_next;
    op_t                w_op;
    logic               w_seterr;
    logic               w_bad;
    logic               w_we;
    logic [ADDR_SZ-1:0] w_waddr;
    logic [DATA_SZ-1:0] w_wdata;

    logic [DATA_SZ-1:0] r_mem [1<<ADDR_SZ];
    logic [ADDR_SZ-1:0] r_link;
    logic [ADDR_SZ-1:0] r_top;
    logic [ADDR_SZ-1:0] r_head;
    logic [ADDR_SZ-1:0] r_count;
    logic [ADDR_SZ-1:0] r_addr;
    logic [DATA_SZ-1:0] r_rdata;
    logic [DATA_SZ-1:0] r_dlat;
    logic               r_err;

    // r_top == 0 means the bump pointer wrapped: every address is live
    assign w_bad = (bus.i_addr == '0) ||
                   ((r_top != '0) && (bus.i_addr >= r_top));

    always_comb begin
        w_next   = r_state;
        w_op     = OP_NONE;
        w_seterr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.i_rd && (bus.i_alloc || bus.i_free))
                    w_seterr = 1'b1;
                else if (bus.i_alloc && bus.i_free)
                    w_op = w_bad ? OP_ERR : OP_RECYC;
                else if (bus.i_alloc)
                    w_op = (r_head != '0) ? OP_POPREQ :
                           (r_top == '0) ? OP_ERR : OP_BUMP;
                else if (bus.i_free)
                    w_op = w_bad ? OP_ERR : OP_FREE;
                else if (bus.i_rd)
                    w_op = w_bad ? OP_ERR : OP_RD;
                if (w_op == OP_POPREQ)
                    w_next = POP;
                else if (w_op != OP_NONE)
                    w_next = DONE;
            end
            POP: begin
                w_op   = OP_POP;
                w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_op == OP_ERR)
            w_seterr = 1'b1;
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        case (w_op)
            OP_BUMP: begin
                w_we    = 1'b1;
                w_waddr = r_top;
                w_wdata = bus.i_data;
            end
            OP_POP: begin
                w_we    = 1'b1;
                w_waddr = r_head;
                w_wdata = r_dlat;
            end
            OP_FREE: begin
                w_we    = 1'b1;
                w_waddr = bus.i_addr;
                w_wdata = DATA_SZ'(r_head);
            end
            OP_RECYC: begin
                w_we    = 1'b1;
                w_waddr = bus.i_addr;
                w_wdata = bus.i_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_link <= r_mem[r_head][ADDR_SZ-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top   <= ADDR_SZ'(1);
            r_head  <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_dlat  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (w_op)
                OP_BUMP: begin
                    r_addr  <= r_top;
                    r_top   <= r_top + ADDR_SZ'(1);
                    r_count <= r_count + ADDR_SZ'(1);
                end
                OP_POPREQ: r_dlat <= bus.i_data;
                OP_POP: begin
                    r_addr  <= r_head;
                    r_head  <= r_link;
                    r_count <= r_count + ADDR_SZ'(1);
                end
                OP_FREE: begin
                    r_head  <= bus.i_addr;
                    r_count <= r_count - ADDR_SZ'(1);
                end
                OP_RECYC: r_addr  <= bus.i_addr;
                OP_RD:    r_rdata <= r_mem[bus.i_addr];
                OP_ERR:   r_addr  <= '0;
                default: ;
            endcase
            if (w_seterr)
                r_err <= 1'b1;
        end
    end

    assign bus.o_busy  = (r_state != IDLE);
    assign bus.o_done  = (r_state == DONE);
    assign bus.o_addr  = r_addr;
    assign bus.o_rdata = r_rdata;
    assign bus.o_count = r_count;
    assign bus.o_error = r_err;
endmodule

// File: tb/tb_heap_alloc.sv
// Directed bench for heap_alloc with ADDR_SZ=4, DATA_SZ=16.
// Latency is counted in rising edges from the accepting edge to o_done.
module tb_heap_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat;

    always #5 clk = ~clk;

    heap_alloc_if #(.DATA_SZ(16), .ADDR_SZ(4)) bus ();

    heap_alloc #(.DATA_SZ(16), .ADDR_SZ(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic a, input logic f, input logic r,
                       input logic [3:0] ad, input logic [15:0] d,
                       output int l);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.o_busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        bus.i_alloc = a;
        bus.i_free  = f;
        bus.i_rd    = r;
        bus.i_addr  = ad;
        bus.i_data  = d;
        @(posedge clk);
        #1;
        bus.i_alloc = 1'b0;
        bus.i_free  = 1'b0;
        bus.i_rd    = 1'b0;
        l = 0;
        for (int c = 1; c <= 4; c++) begin
            if (bus.o_done) begin
                l = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.i_alloc = 1'b0;
        bus.i_free  = 1'b0;
        bus.i_rd    = 1'b0;
        bus.i_addr  = '0;
        bus.i_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  bus.o_busy,  0);
        check("rst_done",  bus.o_done,  0);
        check("rst_addr",  bus.o_addr,  0);
        check("rst_rdata", bus.o_rdata, 0);
        check("rst_count", bus.o_count, 0);
        check("rst_err",   bus.o_error, 0);
        @(negedge clk);
        rst = 1'b0;

        req(1, 0, 0, 0, 16'h1111, lat);
        check("a1_lat", lat, 1);
        check("a1_addr", bus.o_addr, 1);
        req(1, 0, 0, 0, 16'h2222, lat);
        check("a2_lat", lat, 1);
        check("a2_addr", bus.o_addr, 2);
        req(1, 0, 0, 0, 16'h3333, lat);
        check("a3_lat", lat, 1);
        check("a3_addr", bus.o_addr, 3);
        check("a3_count", bus.o_count, 3);
        req(0, 0, 1, 2, 0, lat);
        check("rd2_lat", lat, 1);
        check("rd2_data", bus.o_rdata, 16'h2222);

        req(0, 1, 0, 2, 0, lat);
        check("f2_lat", lat, 1);
        req(0, 1, 0, 1, 0, lat);
        check("f1_count", bus.o_count, 1);
        req(1, 0, 0, 0, 16'hAAAA, lat);
        check("pop1_lat", lat, 2);
        check("pop1_addr", bus.o_addr, 1);
        req(1, 0, 0, 0, 16'hBBBB, lat);
        check("pop2_lat", lat, 2);
        check("pop2_addr", bus.o_addr, 2);
        check("pop2_count", bus.o_count, 3);
        req(1, 0, 0, 0, 16'h4444, lat);
        check("bump4_lat", lat, 1);
        check("bump4_addr", bus.o_addr, 4);
        check("bump4_count", bus.o_count, 4);
        req(0, 0, 1, 1, 0, lat);
        check("rd1_data", bus.o_rdata, 16'hAAAA);
        req(0, 0, 1, 2, 0, lat);
        check("rd2b_data", bus.o_rdata, 16'hBBBB);

        req(1, 1, 0, 3, 16'h5A5A, lat);
        check("rec_lat", lat, 1);
        check("rec_addr", bus.o_addr, 3);
        check("rec_count", bus.o_count, 4);
        req(0, 0, 1, 3, 0, lat);
        check("rd3_data", bus.o_rdata, 16'h5A5A);
        check("noerr", bus.o_error, 0);

        for (int a = 5; a <= 15; a++) begin
            req(1, 0, 0, 0, 16'(a), lat);
            check($sformatf("fill%0d", a), bus.o_addr, a);
        end
        check("full_count", bus.o_count, 15);
        check("full_noerr", bus.o_error, 0);
        req(0, 0, 1, 15, 0, lat);
        check("rd15_data", bus.o_rdata, 15);
        req(1, 0, 0, 0, 16'hDEAD, lat);
        check("ovf_lat", lat, 1);
        check("ovf_err", bus.o_error, 1);
        check("ovf_addr", bus.o_addr, 0);
        check("ovf_count", bus.o_count, 15);

        do_reset();
        check("rst2_err", bus.o_error, 0);
        req(0, 1, 0, 0, 0, lat);
        check("f0_lat", lat, 1);
        check("f0_err", bus.o_error, 1);

        do_reset();
        repeat (3) req(1, 0, 0, 0, 16'h0101, lat);
        check("pre9_err", bus.o_error, 0);
        req(0, 1, 0, 9, 0, lat);
        check("f9_err", bus.o_error, 1);
        check("f9_count", bus.o_count, 3);

        do_reset();
        req(0, 1, 1, 1, 0, lat);
        check("rdfree_nodone", lat, 0);
        check("rdfree_err", bus.o_error, 1);
        check("rdfree_count", bus.o_count, 0);

        do_reset();
        req(1, 0, 0, 0, 16'h0001, lat);
        req(1, 0, 0, 0, 16'h0002, lat);
        req(0, 1, 0, 1, 0, lat);
        @(negedge clk);
        while (bus.o_busy) @(negedge clk);
        bus.i_alloc = 1'b1;
        bus.i_data  = 16'h7777;
        @(posedge clk);
        #1;
        bus.i_alloc = 1'b0;
        check("pop_busy", bus.o_busy, 1);
        check("pop_done", bus.o_done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",  bus.o_busy,  0);
        check("abort_done",  bus.o_done,  0);
        check("abort_count", bus.o_count, 0);
        check("abort_err",   bus.o_error, 0);
        @(negedge clk);
        rst = 1'b0;
        req(1, 0, 0, 0, 16'h8888, lat);
        check("post_lat", lat, 1);
        check("post_addr", bus.o_addr, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
